// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART receive path: default word width, the
// clocking parameters used by the receiver, and the default receive FIFO
// depth. The receiver and the receive FIFO both import this package so
// their word widths agree.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int CLK_FREQ           = 50_000_000;
    localparam int BAUD_RATE          = 115_200;
    localparam int FIFO_DEPTH         = 16;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_if
// Consumer-side stream carrying received bytes out of the receive FIFO.
//   m_data  : head-of-FIFO byte (first-word-fall-through)
//   m_valid : m_data holds a valid byte
//   m_ready : consumer accepts m_data this cycle
//
// Handshake: a transfer happens on every rising clk edge where m_valid and
// m_ready are both high. While m_valid is high and m_ready is low, m_data
// and m_valid hold steady. m_valid never depends on m_ready. m_ready may be
// driven freely and is ignored while m_valid is low.
// ---------------------------------------------------------------------------
interface uart_rx_fifo_if #(
    parameter int DATA_WIDTH = uart_pkg::DEFAULT_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    // FIFO side drives data/valid.
    modport master (
        output m_data,
        output m_valid,
        input  m_ready
    );

    // Consumer side drives ready.
    modport slave (
        input  m_data,
        input  m_valid,
        output m_ready
    );

endinterface : uart_rx_fifo_if

// File: rtl/uart_fifo_mem.sv
// ---------------------------------------------------------------------------
// uart_fifo_mem
// DEPTH x DATA_WIDTH register array with one synchronous write port and one
// asynchronous read port. The storage has no reset; validity of entries is
// tracked by the pointer/level logic in the owning FIFO.
//   clk       : clock
//   wr_en_i   : write wr_data_i into entry wr_addr_i at the clock edge
//   wr_addr_i : write address
//   wr_data_i : write data
//   rd_addr_i : read address
//   rd_data_o : contents of entry rd_addr_i (combinational)
// ---------------------------------------------------------------------------
module uart_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Asynchronous read gives first-word-fall-through at the FIFO output.
    assign rd_data_o = mem_q[rd_addr_i];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Receive-side buffer directly downstream of the UART receiver. Each rising
// edge of the receiver's done strobe pushes rx_data into a circular FIFO;
// the stored bytes are offered to the consumer over a valid/ready stream
// with first-word-fall-through. A byte arriving while the FIFO is full (and
// not being popped in the same cycle) is dropped and sets a sticky overrun
// flag.
//
// Ports:
//   clk         : system clock (same as the UART receiver)
//   rst         : synchronous active-high reset
//   rx_data     : byte from the receiver
//   rx_done     : receiver done strobe, may stay high several cycles
//   m_if        : consumer stream (m_data / m_valid / m_ready)
//   level       : current occupancy, 0..DEPTH
//   full        : level == DEPTH
//   empty       : level == 0
//   overrun     : sticky, a byte was dropped because the FIFO was full
//   overrun_clr : single-cycle clear of overrun
//
// DEPTH must be a power of two (minimum 2) so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     rx_data,
    input  logic                      rx_done,
    uart_rx_fifo_if.master            m_if,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      full,
    output logic                      empty,
    output logic                      overrun,
    input  logic                      overrun_clr
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   LEVEL_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   LEVEL_FULL = (ADDR_WIDTH + 1)'(DEPTH);

    // State
    logic                  rx_done_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q,  level_d;
    logic                  overrun_q, overrun_d;

    // Control
    logic push;
    logic pop;
    logic wr_en;
    logic drop;
    logic is_full;
    logic is_empty;

    // Occupancy flags come from the level counter; pointer equality alone
    // cannot tell full from empty.
    assign is_full  = (level_q == LEVEL_FULL);
    assign is_empty = (level_q == '0);

    always_comb begin
        // One push per strobe, however long the receiver holds done high.
        push = rx_done & ~rx_done_q;
        // m_valid is ~is_empty, so a byte pushed into an empty FIFO cannot
        // be popped in the same cycle.
        pop  = ~is_empty & m_if.m_ready;
        // When full, a simultaneous pop frees the slot the write lands in.
        wr_en = push & (~is_full | pop);
        drop  = push & is_full & ~pop;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        overrun_d = overrun_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({wr_en, pop})
            2'b10:   level_d = level_q + LEVEL_ONE;
            2'b01:   level_d = level_q - LEVEL_ONE;
            default: level_d = level_q;
        endcase

        // Set wins over clear so a drop coinciding with a clear is not lost.
        if (drop) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_done_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            rx_done_q <= rx_done;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
        end
    end

    uart_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (rx_data),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (m_if.m_data)
    );

    assign m_if.m_valid = ~is_empty;
    assign level        = level_q;
    assign full         = is_full;
    assign empty        = is_empty;
    assign overrun      = overrun_q;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Directed bench for uart_rx_fifo. Pushed bytes that should be stored go
// into exp_q when issued; a monitor pops exp_q and compares on every cycle
// where the DUT transfers a byte (m_valid & m_ready).
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int W     = 8;
    localparam int DEPTH = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic [W-1:0] rx_data = '0;
    logic         rx_done = 1'b0;
    logic         overrun_clr = 1'b0;
    logic [4:0]   level;
    logic         full;
    logic         empty;
    logic         overrun;
    logic         stream_done = 1'b0;

    uart_rx_fifo_if #(.DATA_WIDTH(W)) m_if ();

    uart_rx_fifo #(
        .DATA_WIDTH (W),
        .DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .m_if        (m_if),
        .level       (level),
        .full        (full),
        .empty       (empty),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int tests  = 0;
    int failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    // Monitor: sampled on the falling edge; inputs only change just after
    // the rising edge, so this is what the next rising edge will transfer.
    always @(negedge clk) begin
        if (!rst && m_if.m_valid === 1'b1 && m_if.m_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL sb_unexpected: got 0x%0h, expected no transfer", m_if.m_data);
            end else begin
                check("sb_data", 32'(m_if.m_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_byte(input logic [W-1:0] d, input bit expect_stored);
        @(posedge clk); #1;
        rx_done = 1'b1;
        rx_data = d;
        if (expect_stored) exp_q.push_back(d);
        @(posedge clk); #1;
        rx_done = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        @(posedge clk); #1;
        m_if.m_ready = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (empty) done = 1'b1;
        end
        @(posedge clk); #1;
        m_if.m_ready = 1'b0;
        check("drain_done", 32'(done), 32'(1));
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        m_if.m_ready = 1'b0;

        // Reset then idle
        do_reset(2);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_valid", 32'(m_if.m_valid), 32'(0));
            check("idle_empty", 32'(empty), 32'(1));
            check("idle_level", 32'(level), 32'(0));
            check("idle_overrun", 32'(overrun), 32'(0));
        end
        check("idle_full", 32'(full), 32'(0));

        // Single byte, visible right after the capturing edge, stable while held
        push_byte(8'hA5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("single_valid", 32'(m_if.m_valid), 32'(1));
            check("single_data", 32'(m_if.m_data), 32'hA5);
            check("single_level", 32'(level), 32'(1));
        end
        @(posedge clk); #1;
        m_if.m_ready = 1'b1;
        @(posedge clk); #1;
        m_if.m_ready = 1'b0;
        @(negedge clk);
        check("single_pop_empty", 32'(empty), 32'(1));
        check("single_pop_level", 32'(level), 32'(0));
        check("single_pop_valid", 32'(m_if.m_valid), 32'(0));

        // Long strobe: three cycles high gives one entry
        @(posedge clk); #1;
        rx_done = 1'b1;
        rx_data = 8'h3C;
        exp_q.push_back(8'h3C);
        repeat (3) @(posedge clk);
        #1;
        rx_done = 1'b0;
        repeat (2) @(negedge clk);
        check("long_level", 32'(level), 32'(1));
        check("long_data", 32'(m_if.m_data), 32'h3C);
        drain();

        // Fill and overrun
        for (int i = 0; i < DEPTH; i++) push_byte(W'(i), 1'b1);
        @(negedge clk);
        check("fill_full", 32'(full), 32'(1));
        check("fill_level", 32'(level), 32'(16));
        check("fill_overrun", 32'(overrun), 32'(0));
        push_byte(8'h10, 1'b0);
        @(negedge clk);
        check("ovr_full", 32'(full), 32'(1));
        check("ovr_level", 32'(level), 32'(16));
        check("ovr_flag", 32'(overrun), 32'(1));
        check("ovr_head", 32'(m_if.m_data), 32'h00);
        // Dropped push coinciding with a clear: flag stays set
        @(posedge clk); #1;
        rx_done = 1'b1;
        rx_data = 8'h11;
        overrun_clr = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
        overrun_clr = 1'b0;
        @(negedge clk);
        check("ovr_set_wins", 32'(overrun), 32'(1));
        check("ovr_level2", 32'(level), 32'(16));
        drain();
        check("ovr_after_drain", 32'(overrun), 32'(1));
        @(posedge clk); #1;
        overrun_clr = 1'b1;
        @(posedge clk); #1;
        overrun_clr = 1'b0;
        @(negedge clk);
        check("ovr_cleared", 32'(overrun), 32'(0));

        // Simultaneous push and pop at full
        for (int i = 0; i < DEPTH; i++) push_byte(W'(i), 1'b1);
        @(posedge clk); #1;
        rx_done = 1'b1;
        rx_data = 8'h20;
        m_if.m_ready = 1'b1;
        exp_q.push_back(8'h20);
        @(posedge clk); #1;
        rx_done = 1'b0;
        m_if.m_ready = 1'b0;
        @(negedge clk);
        check("pp_level", 32'(level), 32'(16));
        check("pp_full", 32'(full), 32'(1));
        check("pp_overrun", 32'(overrun), 32'(0));
        check("pp_head", 32'(m_if.m_data), 32'h01);
        drain();

        // Wrap-around stream with random consumer stalls
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    for (int w = 0; w < 200 && full; w++) @(posedge clk);
                    push_byte(W'(i * 7 + 3), 1'b1);
                end
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk); #1;
                    m_if.m_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();
        check("stream_overrun", 32'(overrun), 32'(0));

        // Reset mid-operation with five bytes stored
        for (int i = 0; i < 5; i++) push_byte(W'(8'h50 + i), 1'b1);
        @(negedge clk);
        check("mid_level_before", 32'(level), 32'(5));
        do_reset(1);
        @(negedge clk);
        check("mid_level_after", 32'(level), 32'(0));
        check("mid_valid_after", 32'(m_if.m_valid), 32'(0));
        check("mid_empty_after", 32'(empty), 32'(1));
        push_byte(8'h77, 1'b1);
        @(negedge clk);
        check("post_rst_level", 32'(level), 32'(1));
        check("post_rst_data", 32'(m_if.m_data), 32'h77);
        drain();

        check("sb_all_consumed", 32'(exp_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_uart_rx_fifo
